// File: rtl/mod_exp_seq.sv
// mod_exp_seq: sequential modular exponentiator, result = base^exponent mod modulus.
// The exponent is scanned from its most significant bit down (square-and-multiply).
// Each modular multiply is bit-serial and interleaved, so no divider is needed.
//
// Ports:
//   clk      - single clock, all logic on the rising edge
//   rstn     - asynchronous active-low reset
//   start    - request, sampled only while idle
//   base     - WIDTH-bit message/ciphertext, may be >= modulus
//   exponent - EXP_WIDTH-bit exponent
//   modulus  - WIDTH-bit modulus, any value including zero or even values
//   busy     - high while an operation is in progress
//   done     - one-cycle pulse, result/err valid in that cycle
//   result   - registered result, held until the next accepted start
//   err      - set with done when modulus == 0, held until the next accepted start
module mod_exp_seq #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 err
);

  localparam int BW = $clog2(WIDTH);
  localparam int KW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REDUCE = 3'd1;
  localparam logic [2:0] S_SQR    = 3'd2;
  localparam logic [2:0] S_MUL    = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;

  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH+1:0] ZERO_P  = {(WIDTH+2){1'b0}};
  localparam logic [BW-1:0]    TOP_BIT = BW'(WIDTH - 1);
  localparam logic [BW-1:0]    BIT_ONE = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [KW-1:0]    K_TOP   = KW'(EXP_WIDTH - 1);
  localparam logic [KW-1:0]    K_ONE   = {{(KW-1){1'b0}}, 1'b1};
  localparam logic [KW-1:0]    K_ZERO  = {KW{1'b0}};

  logic [2:0]           state_q,  state_d;
  logic [WIDTH-1:0]     base_q,   base_d;
  logic [EXP_WIDTH-1:0] exp_q,    exp_d;
  logic [WIDTH-1:0]     mod_q,    mod_d;
  logic [WIDTH-1:0]     b_q,      b_d;      // base reduced mod N
  logic [WIDTH-1:0]     r_q,      r_d;      // running result
  logic [WIDTH+1:0]     p_q,      p_d;      // partial product of current multiply
  logic [BW-1:0]        bit_q,    bit_d;    // multiplier bit index
  logic [KW-1:0]        k_q,      k_d;      // exponent bit index
  logic                 run_q,    run_d;    // REDUCE has passed its setup cycle
  logic                 busy_q,   busy_d;
  logic                 done_q,   done_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 err_q,    err_d;

  logic [WIDTH-1:0] mm_a, mm_b, mm_res;
  logic [WIDTH+1:0] n_ext, p_add, p_s1, p_s2;
  logic             mm_last;
  logic [2:0]       adv_state;
  logic [KW-1:0]    adv_k;

  // One interleaved multiply step: P = 2P + a[i]*b, then at most two subtractions of N.
  // P < N on entry keeps 2P + b below 3N, so two subtractions restore P < N.
  always_comb begin
    mm_a    = (state_q == S_REDUCE) ? base_q : r_q;
    if (state_q == S_REDUCE) begin
      mm_b = ONE_W;
    end else if (state_q == S_SQR) begin
      mm_b = r_q;
    end else begin
      mm_b = b_q;
    end
    n_ext   = {2'b00, mod_q};
    p_add   = {p_q[WIDTH:0], 1'b0} + (mm_a[bit_q] ? {2'b00, mm_b} : ZERO_P);
    p_s1    = (p_add >= n_ext) ? (p_add - n_ext) : p_add;
    p_s2    = (p_s1 >= n_ext) ? (p_s1 - n_ext) : p_s1;
    mm_res  = p_s2[WIDTH-1:0];
    mm_last = (bit_q == {BW{1'b0}});
    // Exponent walk after a square (bit clear) or a multiply.
    adv_state = (k_q == K_ZERO) ? S_FIN : S_SQR;
    adv_k     = (k_q == K_ZERO) ? k_q : (k_q - K_ONE);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    exp_d    = exp_q;
    mod_d    = mod_q;
    b_d      = b_q;
    r_d      = r_q;
    p_d      = p_q;
    bit_d    = bit_q;
    k_d      = k_q;
    run_d    = run_q;
    done_d   = 1'b0;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d   = base;
          exp_d    = exponent;
          mod_d    = modulus;
          err_d    = 1'b0;
          result_d = ZERO_W;
          run_d    = 1'b0;
          p_d      = ZERO_P;
          bit_d    = TOP_BIT;
          k_d      = K_TOP;
          state_d  = S_REDUCE;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_REDUCE: begin
        if (!run_q) begin
          // Setup cycle: a zero modulus skips straight to the error exit.
          if (mod_q == ZERO_W) begin
            state_d = S_FIN;
          end else begin
            run_d = 1'b1;
            r_d   = (mod_q == ONE_W) ? ZERO_W : ONE_W;
          end
        end else begin
          p_d = p_s2;
          if (mm_last) begin
            b_d     = mm_res;
            p_d     = ZERO_P;
            bit_d   = TOP_BIT;
            state_d = S_SQR;
          end else begin
            bit_d   = bit_q - BIT_ONE;
          end
        end
      end
      S_SQR: begin
        p_d = p_s2;
        if (mm_last) begin
          r_d   = mm_res;
          p_d   = ZERO_P;
          bit_d = TOP_BIT;
          if (exp_q[k_q]) begin
            state_d = S_MUL;
          end else begin
            state_d = adv_state;
            k_d     = adv_k;
          end
        end else begin
          bit_d = bit_q - BIT_ONE;
        end
      end
      S_MUL: begin
        p_d = p_s2;
        if (mm_last) begin
          r_d     = mm_res;
          p_d     = ZERO_P;
          bit_d   = TOP_BIT;
          state_d = adv_state;
          k_d     = adv_k;
        end else begin
          bit_d   = bit_q - BIT_ONE;
        end
      end
      S_FIN: begin
        done_d   = 1'b1;
        err_d    = (mod_q == ZERO_W);
        result_d = (mod_q == ZERO_W) ? ZERO_W : r_q;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers, cleared asynchronously by rstn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      base_q   <= ZERO_W;
      exp_q    <= {EXP_WIDTH{1'b0}};
      mod_q    <= ZERO_W;
      b_q      <= ZERO_W;
      r_q      <= ZERO_W;
      p_q      <= ZERO_P;
      bit_q    <= {BW{1'b0}};
      k_q      <= K_ZERO;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= ZERO_W;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      mod_q    <= mod_d;
      b_q      <= b_d;
      r_q      <= r_d;
      p_q      <= p_d;
      bit_q    <= bit_d;
      k_q      <= k_d;
      run_q    <= run_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule
